cp0_exc_ctrl: RTL

CP0_EXC_CTRL -- requirements
Module: cp0_exc_ctrl

---
 rtl/cp0_exc_ctrl_pkg.sv | 64 ++++++
 rtl/cp0_exc_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 definitions for the exception controller: register addresses,
// FSM encoding, ExcCodes, Status/Cause field positions and the output bundle.
package cp0_exc_ctrl_pkg;

  localparam logic [4:0] CP0_ADDR_STATUS = 5'd12;
  localparam logic [4:0] CP0_ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_ADDR_EPC    = 5'd14;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_W_EPC    = 3'd1,
    ST_W_CAUSE  = 3'd2,
    ST_W_STATUS = 3'd3,
    ST_W_ERET   = 3'd4
  } state_e;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int STATUS_IE    = 0;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IM_LO = 8;
  localparam int STATUS_IM_HI = 15;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 8;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_BD     = 31;

  // Everything captured at acceptance; the write sequence never looks at live inputs.
  typedef struct packed {
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] saved_epc;
    logic [31:0] eret_pc;
    logic [4:0]  code;
    logic        bd;
  } snap_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] data;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall;
  } cp0_out_t;

  function automatic logic [31:0] cause_with_exc(input logic [31:0] cause,
                                                 input logic        bd,
                                                 input logic [4:0]  code);
    logic [31:0] r;
    r = cause;
    r[CAUSE_BD] = bd;
    r[CAUSE_EXC_HI:CAUSE_EXC_LO] = code;
    return r;
  endfunction

endpackage

// File: rtl/cp0_exc_ctrl.sv
// MEM-stage exception/ERET controller: accepts one event from IDLE, then drives
// the EPC/Cause/Status write sequence (or the single ERET Status write) with flush.
module cp0_exc_ctrl
  import cp0_exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid_i,
  input  logic [4:0]  exc_code_i,
  input  logic        eret_i,
  input  logic        inst_valid_i,
  input  logic [31:0] pc_i,
  input  logic        in_delay_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  output logic        cp0_we_o,
  output logic [4:0]  cp0_waddr_o,
  output logic [31:0] cp0_data_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        stall_o
);

  state_e   r_state;
  state_e   w_state_nxt;
  snap_t    r_snap;
  snap_t    w_snap_nxt;
  cp0_out_t r_out;
  cp0_out_t w_out_nxt;

  logic w_int_pend;
  logic w_accept_trap;
  logic w_accept_eret;

  assign w_int_pend = inst_valid_i
                    & status_i[STATUS_IE]
                    & ~status_i[STATUS_EXL]
                    & (|(cause_i[CAUSE_IP_HI:CAUSE_IP_LO] & status_i[STATUS_IM_HI:STATUS_IM_LO]));

  // An exception outranks a simultaneous ERET, so ERET only wins when nothing else is pending.
  assign w_accept_trap = (r_state == ST_IDLE) & (w_int_pend | exc_valid_i);
  assign w_accept_eret = (r_state == ST_IDLE) & ~w_int_pend & ~exc_valid_i & eret_i;

  // NOTE: state, snapshot and output registers use non-blocking assignments so
  // every flop samples pre-edge values; the comb blocks below use blocking ones.
  // NOTE: the snapshot is reset too, so a reset mid-sequence leaves no stale
  // Status/Cause data that a later decode could leak onto cp0_data_o.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_snap  <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_snap  <= w_snap_nxt;
      r_out   <= w_out_nxt;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns; no latch is inferred.
    w_state_nxt = r_state;
    w_snap_nxt  = r_snap;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept_trap) begin
          w_state_nxt          = ST_W_EPC;
          w_snap_nxt.status    = status_i;
          w_snap_nxt.cause     = cause_i;
          w_snap_nxt.code      = w_int_pend ? EXC_INT : exc_code_i;
          w_snap_nxt.bd        = in_delay_i;
          w_snap_nxt.saved_epc = in_delay_i ? (pc_i - 32'd4) : pc_i;
          w_snap_nxt.eret_pc   = epc_i;
        end else if (w_accept_eret) begin
          w_state_nxt          = ST_W_ERET;
          w_snap_nxt.status    = status_i;
          w_snap_nxt.cause     = cause_i;
          w_snap_nxt.code      = EXC_INT;
          w_snap_nxt.bd        = in_delay_i;
          w_snap_nxt.saved_epc = in_delay_i ? (pc_i - 32'd4) : pc_i;
          w_snap_nxt.eret_pc   = epc_i;
        end
      end
      ST_W_EPC:    w_state_nxt = ST_W_CAUSE;
      ST_W_CAUSE:  w_state_nxt = ST_W_STATUS;
      ST_W_STATUS: w_state_nxt = ST_IDLE;
      ST_W_ERET:   w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the state and snapshot being entered, then registered,
  // so they appear the cycle after acceptance and never glitch.
  always_comb begin
    logic [31:0] status_set;
    logic [31:0] status_clr;
    w_out_nxt  = '0;
    status_set = w_snap_nxt.status;
    status_clr = w_snap_nxt.status;
    status_set[STATUS_EXL] = 1'b1;
    status_clr[STATUS_EXL] = 1'b0;
    unique case (w_state_nxt)
      ST_W_EPC: begin
        w_out_nxt.we     = 1'b1;
        w_out_nxt.waddr  = CP0_ADDR_EPC;
        w_out_nxt.data   = w_snap_nxt.saved_epc;
        w_out_nxt.flush  = 1'b1;
        w_out_nxt.new_pc = EXC_VECTOR;
        w_out_nxt.stall  = 1'b1;
      end
      ST_W_CAUSE: begin
        w_out_nxt.we    = 1'b1;
        w_out_nxt.waddr = CP0_ADDR_CAUSE;
        w_out_nxt.data  = cause_with_exc(w_snap_nxt.cause, w_snap_nxt.bd, w_snap_nxt.code);
        w_out_nxt.stall = 1'b1;
      end
      ST_W_STATUS: begin
        w_out_nxt.we    = 1'b1;
        w_out_nxt.waddr = CP0_ADDR_STATUS;
        w_out_nxt.data  = status_set;
        w_out_nxt.stall = 1'b1;
      end
      ST_W_ERET: begin
        w_out_nxt.we     = 1'b1;
        w_out_nxt.waddr  = CP0_ADDR_STATUS;
        w_out_nxt.data   = status_clr;
        w_out_nxt.flush  = 1'b1;
        w_out_nxt.new_pc = w_snap_nxt.eret_pc;
      end
      default: w_out_nxt = '0;
    endcase
  end

  assign cp0_we_o    = r_out.we;
  assign cp0_waddr_o = r_out.waddr;
  assign cp0_data_o  = r_out.data;
  assign flush_o     = r_out.flush;
  assign new_pc_o    = r_out.new_pc;
  assign stall_o     = r_out.stall;

endmodule
